// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: fetch FSM states and reset constants.
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_REQ  = 3'd1,
    F_WAIT = 3'd2,
    F_HOLD = 3'd3,
    F_ERR  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with a one-entry deferred write slot and misaligned-target rejection.
// Writes land directly while the fetch FSM is idle; during a fetch they are parked
// and committed on the edge the fetch completes or times out.
module pc_register
  import core_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_wdata,
  input  logic            direct_ok,
  input  logic            apply_pending,
  output logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] fetch_addr,
  output logic            misalign
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_data_q, pend_data_d;
  logic            pend_valid_q, pend_valid_d;
  logic            misalign_q, misalign_d;
  logic            wr_ok;

  assign wr_ok      = pc_we && (pc_wdata[1:0] == 2'b00);
  assign fetch_addr = wr_ok ? pc_wdata : pc_q;
  assign pc_cur     = pc_q;
  assign misalign   = misalign_q;

  // Next PC: direct load when idle, park writes during a fetch, newest write wins on commit.
  always_comb begin
    pc_d         = pc_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    misalign_d   = pc_we && (pc_wdata[1:0] != 2'b00);
    if (direct_ok) begin
      if (wr_ok) pc_d = pc_wdata;
    end else if (apply_pending) begin
      if (wr_ok)             pc_d = pc_wdata;
      else if (pend_valid_q) pc_d = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (wr_ok) begin
      pend_valid_d = 1'b1;
      pend_data_d  = pc_wdata;
    end
  end

  // PC, pending slot and misalign pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= XLEN'(RESET_PC);
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the memory read handshake with a bus
// timeout, and latches the fetched instruction and its PC for decode.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_we,
  input  logic [XLEN-1:0] pc_wdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_old,
  output logic [XLEN-1:0] pc_plus4,
  output logic            busy,
  output logic            fetch_fault,
  output logic            misalign
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  fetch_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_old_q, pc_old_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] fetch_addr;
  logic            direct_ok;
  logic            apply_pending;

  assign direct_ok   = (state_q == F_IDLE) || (state_q == F_HOLD) || (state_q == F_ERR);
  assign busy        = (state_q == F_REQ) || (state_q == F_WAIT);
  assign mem_req     = busy;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_old      = pc_old_q;
  assign fetch_fault = (state_q == F_ERR);
  assign pc_plus4    = pc_cur + XLEN'(4);

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .pc_we         (pc_we),
    .pc_wdata      (pc_wdata),
    .direct_ok     (direct_ok),
    .apply_pending (apply_pending),
    .pc_cur        (pc_cur),
    .fetch_addr    (fetch_addr),
    .misalign      (misalign)
  );

  // Fetch sequencing: start, one request cycle, wait for ready or time out, then hold.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    pc_old_d      = pc_old_q;
    mem_addr_d    = mem_addr_q;
    apply_pending = 1'b0;
    case (state_q)
      F_IDLE, F_HOLD, F_ERR: begin
        if (fetch_start) begin
          state_d    = F_REQ;
          valid_d    = 1'b0;
          mem_addr_d = fetch_addr;
        end
      end
      F_REQ: begin
        pc_old_d = pc_cur;
        cnt_d    = '0;
        state_d  = F_WAIT;
      end
      F_WAIT: begin
        if (mem_ready) begin
          instr_d       = mem_rdata;
          valid_d       = 1'b1;
          state_d       = F_HOLD;
          apply_pending = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          valid_d       = 1'b0;
          state_d       = F_ERR;
          apply_pending = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  // State, timeout counter and fetch result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= F_IDLE;
      cnt_q      <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      pc_old_q   <= XLEN'(RESET_PC);
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pc_old_q   <= pc_old_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_we = 1'b0;
  logic [31:0] pc_wdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_cur;
  logic [31:0] pc_old;
  logic [31:0] pc_plus4;
  logic        busy;
  logic        fetch_fault;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  instr_fetch_unit #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_we       (pc_we),
    .pc_wdata    (pc_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_cur      (pc_cur),
    .pc_old      (pc_old),
    .pc_plus4    (pc_plus4),
    .busy        (busy),
    .fetch_fault (fetch_fault),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (pc_cur !== 32'h0) begin failures++; $display("FAIL reset_pc_cur got=%h exp=%h", pc_cur, 32'h0); end
    checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h13); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (fetch_fault !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", fetch_fault, misalign); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_req got=%b%b exp=11", mem_req, busy); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL basic_addr got=%h exp=0", mem_addr); end
    tick();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL basic_wait_req got=%b exp=1", mem_req); end
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    tick();
    mem_ready = 1'b0;
    checks++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b1) begin failures++; $display("FAIL basic_instr got=%h/%b exp=00000013/1", instr, instr_valid); end
    checks++; if (pc_old !== 32'h0) begin failures++; $display("FAIL basic_pc_old got=%h exp=0", pc_old); end
    checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL basic_pc_plus4 got=%h exp=4", pc_plus4); end
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL basic_hold_idle got=%b%b exp=00", busy, mem_req); end
  endtask

  task automatic test_deferred_pc_write();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    pc_we = 1'b1;
    pc_wdata = 32'h8;
    tick();
    pc_we = 1'b0;
    checks++; if (pc_cur !== 32'h0 || mem_addr !== 32'h0) begin failures++; $display("FAIL defer_in_wait got pc=%h addr=%h exp 0/0", pc_cur, mem_addr); end
    mem_ready = 1'b1;
    mem_rdata = 32'h0010_0093;
    tick();
    mem_ready = 1'b0;
    checks++; if (pc_cur !== 32'h8) begin failures++; $display("FAIL defer_applied got=%h exp=8", pc_cur); end
    checks++; if (instr !== 32'h0010_0093 || pc_old !== 32'h0) begin failures++; $display("FAIL defer_instr got=%h/%h exp=00100093/0", instr, pc_old); end
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checks++; if (mem_addr !== 32'h8) begin failures++; $display("FAIL defer_next_addr got=%h exp=8", mem_addr); end
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h0020_0113;
    tick();
    mem_ready = 1'b0;
    checks++; if (pc_old !== 32'h8 || instr !== 32'h0020_0113) begin failures++; $display("FAIL defer_second got=%h/%h exp=8/00200113", pc_old, instr); end
  endtask

  task automatic test_timeout();
    int early_fault;
    early_fault = 0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      if (fetch_fault !== 1'b0) early_fault++;
    end
    checks++; if (early_fault !== 0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", early_fault); end
    tick();
    checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b exp=1", fetch_fault); end
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL timeout_idle got=%b%b%b exp=000", instr_valid, busy, mem_req); end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    checks++; if (instr !== 32'h0020_0113 || fetch_fault !== 1'b1) begin failures++; $display("FAIL timeout_ignore_ready got=%h/%b exp=00200113/1", instr, fetch_fault); end
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || mem_addr !== 32'h8) begin failures++; $display("FAIL timeout_clear got=%b/%h exp=0/8", fetch_fault, mem_addr); end
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h0030_0193;
    tick();
    mem_ready = 1'b0;
    checks++; if (instr !== 32'h0030_0193 || instr_valid !== 1'b1) begin failures++; $display("FAIL timeout_refetch got=%h/%b exp=00300193/1", instr, instr_valid); end
  endtask

  task automatic test_misalign();
    pc_we = 1'b1;
    pc_wdata = 32'h6;
    tick();
    pc_we = 1'b0;
    checks++; if (misalign !== 1'b1 || pc_cur !== 32'h8) begin failures++; $display("FAIL misalign_pulse got=%b/%h exp=1/8", misalign, pc_cur); end
    tick();
    checks++; if (misalign !== 1'b0 || pc_cur !== 32'h8) begin failures++; $display("FAIL misalign_end got=%b/%h exp=0/8", misalign, pc_cur); end
    pc_we = 1'b1;
    pc_wdata = 32'hFFFF_FFFC;
    tick();
    pc_we = 1'b0;
    checks++; if (pc_cur !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4 got=%h/%h exp=fffffffc/0", pc_cur, pc_plus4); end
  endtask

  task automatic test_back_to_back();
    pc_we = 1'b1;
    pc_wdata = 32'h40;
    fetch_start = 1'b1;
    tick();
    pc_we = 1'b0;
    fetch_start = 1'b0;
    checks++; if (mem_addr !== 32'h40 || pc_cur !== 32'h40) begin failures++; $display("FAIL bypass_addr got=%h/%h exp=40/40", mem_addr, pc_cur); end
    tick();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    checks++; if (busy !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL ignore_start_wait got=%b/%h exp=1/40", busy, mem_addr); end
    mem_ready = 1'b1;
    mem_rdata = 32'h0040_0213;
    tick();
    mem_ready = 1'b0;
    checks++; if (pc_old !== 32'h40 || instr !== 32'h0040_0213 || busy !== 1'b0) begin failures++; $display("FAIL bypass_done got=%h/%h/%b exp=40/00400213/0", pc_old, instr, busy); end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset_req got=%b%b exp=00", mem_req, busy); end
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ready = 1'b0;
    checks++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin failures++; $display("FAIL late_ready got=%h/%b exp=00000013/0", instr, instr_valid); end
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || pc_cur !== 32'h0) begin failures++; $display("FAIL reset_idle got=%b%b/%h exp=00/0", busy, mem_req, pc_cur); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_deferred_pc_write();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
